sb_cfg_loader: RTL and testbench

Serial configuration loader that writes the direction/enable control bits of a row of switch boxes. It accepts a framed serial bitstream over a valid/ready bit handshake, checks the frame's header and checksum, and then updates all switch-box controls in one atomic step. Enables are blanked for one cycle before new directions take effect, so no bidirectional buffer ever drives against a stale direction. It sits between the configuration port and the routing fabric; each switch box takes 6 dir and 6 en bits.

---
 rtl/sb_cfg_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_sb_cfg_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_loader.sv
// Serial configuration loader for a row of switch boxes: framed, checksummed, atomic commit with enable blanking.
// Defining CFG_READBACK_EN adds a serialiser that replays the committed controls in load-frame format.

module sb_cfg_loader #(
    parameter int NUM_SB = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_din,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [NUM_SB*6-1:0] sb_dir,
    output logic [NUM_SB*6-1:0] sb_en
`ifdef CFG_READBACK_EN
    ,
    input  logic                rb_start,
    output logic                rb_dout,
    output logic                rb_valid
`endif
);

    localparam int plen  = NUM_SB * 12;
    localparam int bw    = NUM_SB * 6;
    localparam int cnt_w = $clog2(plen + 1);
    localparam logic [7:0] hdr_val = 8'hA5;

    typedef enum logic [2:0] {
        st_idle   = 3'd0,
        st_hdr    = 3'd1,
        st_load   = 3'd2,
        st_csum   = 3'd3,
        st_blank  = 3'd4,
        st_commit = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [cnt_w-1:0] cnt_r;
    logic [7:0]       shift_r, csum_r, hdr_word_s, csum_word_s;
    logic [plen-1:0]  shadow_r;
    logic [bw-1:0]    shadow_dir_s, shadow_en_s, dir_r, en_r;
    logic             ready_r, done_r, err_r;
    logic             take_s, start_ok_s, err_set_s, rb_busy_s;
    logic             byte_last_s, load_last_s;

    // ready_r mirrors "state is HDR/LOAD/CSUM", so it doubles as the bit-accept qualifier
    assign take_s      = cfg_valid && ready_r;
    assign start_ok_s  = cfg_start && (state_r == st_idle) && !rb_busy_s;
    assign hdr_word_s  = {shift_r[6:0], cfg_din};
    assign csum_word_s = {cfg_din, shift_r[7:1]};
    assign byte_last_s = (cnt_r == cnt_w'(7));
    assign load_last_s = (cnt_r == cnt_w'(plen - 1));

    // Next-state logic and error detection
    always_comb begin
        state_s   = state_r;
        err_set_s = 1'b0;
        case (state_r)
            st_idle: begin
                if (start_ok_s) state_s = st_hdr;
                else            state_s = st_idle;
            end
            st_hdr: begin
                if (take_s && byte_last_s) begin
                    if (hdr_word_s != hdr_val) begin
                        state_s   = st_idle;
                        err_set_s = 1'b1;
                    end else begin
                        state_s = st_load;
                    end
                end else begin
                    state_s = st_hdr;
                end
            end
            st_load: begin
                if (take_s && load_last_s) state_s = st_csum;
                else                       state_s = st_load;
            end
            st_csum: begin
                if (take_s && byte_last_s) begin
                    if (csum_word_s == csum_r) begin
                        state_s = st_blank;
                    end else begin
                        state_s   = st_idle;
                        err_set_s = 1'b1;
                    end
                end else begin
                    state_s = st_csum;
                end
            end
            st_blank:  state_s = st_commit;
            st_commit: state_s = st_idle;
            default:   state_s = st_idle;
        endcase
    end

    // Split the payload-ordered shadow into per-box dir/en fields
    always_comb begin
        shadow_dir_s = '0;
        shadow_en_s  = '0;
        for (int k = 0; k < NUM_SB; k++) begin
            for (int b = 0; b < 6; b++) begin
                shadow_dir_s[6*k+b] = shadow_r[12*k+b];
                shadow_en_s[6*k+b]  = shadow_r[12*k+6+b];
            end
        end
    end

    // State register and registered control/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= st_idle;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            dir_r   <= '0;
            en_r    <= '0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == st_hdr) || (state_s == st_load) || (state_s == st_csum);
            done_r  <= (state_s == st_commit);
            if (start_ok_s)     err_r <= 1'b0;
            else if (err_set_s) err_r <= 1'b1;
            else                err_r <= err_r;
            // Enables drop for one cycle while directions switch, then come back
            case (state_s)
                st_blank: begin
                    en_r  <= '0;
                    dir_r <= shadow_dir_s;
                end
                st_commit: en_r <= shadow_en_s;
                default: begin
                    en_r  <= en_r;
                    dir_r <= dir_r;
                end
            endcase
        end
    end

    // Bit counter, header/checksum shifter, shadow payload and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            shift_r  <= 8'h00;
            csum_r   <= 8'h00;
            shadow_r <= '0;
        end else if (start_ok_s) begin
            cnt_r    <= '0;
            shift_r  <= 8'h00;
            csum_r   <= 8'h00;
            shadow_r <= '0;
        end else if (take_s) begin
            cnt_r <= (state_s != state_r) ? '0 : cnt_r + cnt_w'(1);
            case (state_r)
                st_hdr: shift_r <= hdr_word_s;
                st_load: begin
                    shadow_r[cnt_r]       <= cfg_din;
                    csum_r[cnt_r[2:0]]    <= csum_r[cnt_r[2:0]] ^ cfg_din;
                end
                st_csum: shift_r <= csum_word_s;
                default: shift_r <= shift_r;
            endcase
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cfg_ready = ready_r;
    assign cfg_done  = done_r;
    assign cfg_err   = err_r;
    assign sb_dir    = dir_r;
    assign sb_en     = en_r;

`ifdef CFG_READBACK_EN
    localparam int flen = plen + 16;
    localparam int rb_w = $clog2(flen);

    function automatic logic [7:0] payload_csum(input logic [plen-1:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int j = 0; j < plen; j++) c[j % 8] = c[j % 8] ^ p[j];
        return c;
    endfunction

    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    logic [plen-1:0] rb_payload_s;
    logic [flen-1:0] rb_frame_s;
    logic [flen-2:0] rb_sh_r;
    logic [rb_w-1:0] rb_left_r;
    logic            rb_valid_r, rb_dout_r, rb_go_s;

    // Frame image, LSB sent first: header MSB-first, payload, checksum
    always_comb begin
        rb_payload_s = '0;
        for (int k = 0; k < NUM_SB; k++) begin
            for (int b = 0; b < 6; b++) begin
                rb_payload_s[12*k+b]   = dir_r[6*k+b];
                rb_payload_s[12*k+6+b] = en_r[6*k+b];
            end
        end
        rb_frame_s = {payload_csum(rb_payload_s), rb_payload_s, bit_rev8(hdr_val)};
    end

    // A simultaneous cfg_start takes priority over readback
    assign rb_go_s   = rb_start && (state_r == st_idle) && !cfg_start && !rb_valid_r;
    assign rb_busy_s = rb_valid_r;

    // Readback serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_valid_r <= 1'b0;
            rb_dout_r  <= 1'b0;
            rb_sh_r    <= '0;
            rb_left_r  <= '0;
        end else if (rb_go_s) begin
            rb_valid_r <= 1'b1;
            rb_dout_r  <= rb_frame_s[0];
            rb_sh_r    <= rb_frame_s[flen-1:1];
            rb_left_r  <= rb_w'(flen - 1);
        end else if (rb_valid_r) begin
            if (rb_left_r == '0) begin
                rb_valid_r <= 1'b0;
                rb_dout_r  <= 1'b0;
            end else begin
                rb_dout_r <= rb_sh_r[0];
                rb_sh_r   <= {1'b0, rb_sh_r[flen-2:1]};
                rb_left_r <= rb_left_r - rb_w'(1);
            end
        end else begin
            rb_valid_r <= 1'b0;
        end
    end

    assign rb_dout  = rb_dout_r;
    assign rb_valid = rb_valid_r;
`else
    assign rb_busy_s = 1'b0;
`endif

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Randomised self-checking bench for sb_cfg_loader (NUM_SB=2) against a frame-level reference model.
module tb_sb_cfg_loader;

    localparam int NSB = 2;
    localparam int P   = NSB * 12;
    localparam int W   = NSB * 6;

    logic         clk = 1'b0;
    logic         rst_n, cfg_start, cfg_din, cfg_valid;
    logic         cfg_ready, cfg_done, cfg_err;
    logic [W-1:0] sb_dir, sb_en;
`ifdef CFG_READBACK_EN
    logic         rb_start, rb_dout, rb_valid;
`endif

    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_dir, exp_en;
    bit           frame_q[$];

    sb_cfg_loader #(.NUM_SB(NSB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_din   (cfg_din),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .sb_dir    (sb_dir),
        .sb_en     (sb_en)
`ifdef CFG_READBACK_EN
        ,
        .rb_start  (rb_start),
        .rb_dout   (rb_dout),
        .rb_valid  (rb_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: header MSB first, payload box by box (dir0..5, en0..5), checksum by position mod 8
    task automatic build_frame(input logic [W-1:0] d, input logic [W-1:0] e,
                               input logic [7:0] hdr_x, input logic [7:0] cs_x);
        logic [7:0] hdr, cs;
        int k, r;
        bit b;
        frame_q.delete();
        hdr = 8'hA5 ^ hdr_x;
        for (int i = 7; i >= 0; i--) frame_q.push_back(hdr[i]);
        cs = 8'h00;
        for (int j = 0; j < P; j++) begin
            k = j / 12;
            r = j % 12;
            b = (r < 6) ? d[6*k + r] : e[6*k + r - 6];
            frame_q.push_back(b);
            cs[j % 8] = cs[j % 8] ^ b;
        end
        cs = cs ^ cs_x;
        for (int i = 0; i < 8; i++) frame_q.push_back(cs[i]);
    endtask

    task automatic run_frame(input logic [W-1:0] d, input logic [W-1:0] e,
                             input logic [7:0] hdr_x, input logic [7:0] cs_x,
                             input int gap_mode, input bit poke);
        bit good, v, stop;
        int idx, cyc, exp_taken;
        good = (hdr_x == 8'h00) && (cs_x == 8'h00);
        build_frame(d, e, hdr_x, cs_x);
        exp_taken = (hdr_x != 8'h00) ? 8 : frame_q.size();
        @(negedge clk) cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
        check_eq("start_ready", 64'(cfg_ready), 64'd1);
        check_eq("start_err_clear", 64'(cfg_err), 64'd0);
        idx = 0; cyc = 0; stop = 1'b0;
        while (!stop && idx < frame_q.size() && cyc < 400) begin
            if (!cfg_ready) begin
                stop = 1'b1;
            end else begin
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = 1'($urandom_range(1, 0));
                endcase
                cfg_valid = v;
                cfg_din   = v ? frame_q[idx] : 1'($urandom_range(1, 0));
                cfg_start = poke && (idx >= 8 + P/2) && (idx < 8 + P/2 + 2);
`ifdef CFG_READBACK_EN
                rb_start  = poke && (idx >= 4) && (idx < 6);
`endif
                @(negedge clk);
                cyc++;
                if (v) idx++;
            end
        end
        cfg_valid = 1'b0; cfg_start = 1'b0; cfg_din = 1'b0;
`ifdef CFG_READBACK_EN
        rb_start = 1'b0;
`endif
        check_eq("bits_taken", 64'(idx), 64'(exp_taken));
        if (good) begin
            check_eq("blank_en", 64'(sb_en), 64'd0);
            check_eq("blank_dir", 64'(sb_dir), 64'(d));
            check_eq("blank_done", 64'(cfg_done), 64'd0);
            check_eq("blank_ready", 64'(cfg_ready), 64'd0);
            @(negedge clk);
            check_eq("commit_en", 64'(sb_en), 64'(e));
            check_eq("commit_dir", 64'(sb_dir), 64'(d));
            check_eq("commit_done", 64'(cfg_done), 64'd1);
            check_eq("commit_err", 64'(cfg_err), 64'd0);
            @(negedge clk);
            check_eq("done_pulse", 64'(cfg_done), 64'd0);
            check_eq("idle_ready", 64'(cfg_ready), 64'd0);
`ifdef CFG_READBACK_EN
            check_eq("rb_ignored", 64'(rb_valid), 64'd0);
`endif
            exp_dir = d;
            exp_en  = e;
        end else begin
            check_eq("err_set", 64'(cfg_err), 64'd1);
            check_eq("err_ready", 64'(cfg_ready), 64'd0);
            check_eq("err_dir_kept", 64'(sb_dir), 64'(exp_dir));
            check_eq("err_en_kept", 64'(sb_en), 64'(exp_en));
            check_eq("err_done", 64'(cfg_done), 64'd0);
            @(negedge clk);
            check_eq("err_sticky", 64'(cfg_err), 64'd1);
            check_eq("err_no_done", 64'(cfg_done), 64'd0);
        end
    endtask

`ifdef CFG_READBACK_EN
    task automatic check_readback();
        logic [63:0] got, expf;
        int n;
        build_frame(exp_dir, exp_en, 8'h00, 8'h00);
        expf = 64'd0;
        for (int i = 0; i < frame_q.size() && i < 64; i++) expf[i] = frame_q[i];
        @(negedge clk) rb_start = 1'b1;
        @(negedge clk) rb_start = 1'b0;
        cfg_start = 1'b1;
        check_eq("rb_valid_first", 64'(rb_valid), 64'd1);
        got = 64'd0;
        n = 0;
        while (rb_valid && n < 100) begin
            if (n < 64) got[n] = rb_dout;
            n++;
            @(negedge clk);
            cfg_start = 1'b0;
        end
        cfg_start = 1'b0;
        check_eq("rb_len", 64'(n), 64'(frame_q.size()));
        check_eq("rb_frame", got, expf);
        check_eq("rb_start_blocked", 64'(cfg_ready), 64'd0);
    endtask
`endif

    initial begin
        logic [W-1:0] d, e;
        logic [7:0]   hx, cx;
        int           sel;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_din = 1'b0; cfg_valid = 1'b0;
`ifdef CFG_READBACK_EN
        rb_start = 1'b0;
`endif
        exp_dir = '0; exp_en = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_dir", 64'(sb_dir), 64'd0);
        check_eq("rst_en", 64'(sb_en), 64'd0);
        check_eq("rst_ready", 64'(cfg_ready), 64'd0);
        check_eq("rst_done", 64'(cfg_done), 64'd0);
        check_eq("rst_err", 64'(cfg_err), 64'd0);
`ifdef CFG_READBACK_EN
        check_eq("rst_rb_valid", 64'(rb_valid), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Valid bits while idle must be ignored
        for (int i = 0; i < 6; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check_eq("idle_noise_ready", 64'(cfg_ready), 64'd0);
        check_eq("idle_noise_dir", 64'(sb_dir), 64'd0);

        run_frame(12'h001, 12'h001, 8'h00, 8'h00, 0, 1'b0);
`ifdef CFG_READBACK_EN
        check_readback();
`endif
        run_frame(12'h001, 12'h001, 8'h00, 8'h01, 0, 1'b0);
        run_frame(12'h5A3, 12'hC3C, 8'h00, 8'h10, 2, 1'b0);
        run_frame(12'h777, 12'h111, 8'h01, 8'h00, 0, 1'b0);
        run_frame(12'h001, 12'h001, 8'h00, 8'h00, 1, 1'b1);

        for (int it = 0; it < 24; it++) begin
            d   = W'($urandom());
            e   = W'($urandom());
            sel = $urandom_range(5, 0);
            hx  = (sel == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
            cx  = (sel == 1) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
            run_frame(d, e, hx, cx, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
`ifdef CFG_READBACK_EN
            if (sel == 2) check_readback();
`endif
        end

        run_frame(12'hFA5, 12'h9E7, 8'h00, 8'h00, 0, 1'b0);
        // Reset in the middle of LOAD
        @(negedge clk) cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_dir", 64'(sb_dir), 64'd0);
        check_eq("midrst_en", 64'(sb_en), 64'd0);
        check_eq("midrst_ready", 64'(cfg_ready), 64'd0);
        check_eq("midrst_err", 64'(cfg_err), 64'd0);
        cfg_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_dir = '0; exp_en = '0;
        run_frame(12'h3C5, 12'hA0F, 8'h00, 8'h00, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
